// File: rtl/async_receiver_if.sv
// Serial receive link bundle: the RxD line plus everything the receiver reports downstream.
// slave is the receiver side; master is the line driver / consumer side.
interface async_receiver_if;
   logic       RxD;
   logic [7:0] RxD_data;
   logic       RxD_data_ready;
   logic       RxD_framing_err;
   logic       RxD_busy;
   logic       RxD_idle;

   modport master (
      output RxD,
      input  RxD_data, RxD_data_ready, RxD_framing_err, RxD_busy, RxD_idle
   );

   modport slave (
      input  RxD,
      output RxD_data, RxD_data_ready, RxD_framing_err, RxD_busy, RxD_idle
   );
endinterface

// File: rtl/async_receiver.sv
// 8N1 UART receiver: oversampled, majority-filtered RxD, LSB-first assembly,
// one-clock data/framing strobes and a line-idle flag.
//
// state  | meaning
// sIdle  | waiting for a low rx_bit (start edge); idle counter runs here
// sStart | counting to mid start bit to reject glitches
// sData  | sampling 8 data bits at mid bit
// sStop  | sampling the stop bit at mid bit
// sBreak | stop bit was low; waiting for the line to return high
module async_receiver #(
   parameter int     ClkFrequency = 50000000,
   parameter int     Baud         = 115200,
   parameter int     Oversampling = 16,
   parameter int     AccWidth     = 16,
   parameter longint AccInc       = (longint'(Baud) * Oversampling * (longint'(1) << AccWidth)
                                     + ClkFrequency / 2) / ClkFrequency
) (
   input logic             clk,
   input logic             rst_n,
   async_receiver_if.slave rx
);
   localparam int PhaseW  = $clog2(Oversampling);
   localparam int IdleMax = 10 * Oversampling;
   localparam int IdleW   = $clog2(IdleMax + 1);
   localparam logic [AccWidth:0] AccStep  = AccInc[AccWidth:0];
   localparam logic [PhaseW-1:0] PhaseMid = PhaseW'(Oversampling / 2 - 1);
   localparam logic [PhaseW-1:0] PhaseEnd = PhaseW'(Oversampling - 1);

   typedef enum logic [2:0] {sIdle, sStart, sData, sStop, sBreak} state_t;

   state_t            state, stateNext;
   logic [AccWidth:0] acc;
   logic              tick;
   logic [1:0]        syncFf;
   logic [2:0]        hist;
   logic              rxBit;
   logic [PhaseW-1:0] phase, phaseNext;
   logic [2:0]        bitCnt, bitCntNext;
   logic [7:0]        shiftReg, shiftNext;
   logic [IdleW-1:0]  idleCnt;
   logic              loadData, frameErr;

   assign tick  = acc[AccWidth];
   assign rxBit = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         syncFf <= 2'b11;
         hist   <= 3'b111;
      end else begin
         acc    <= {1'b0, acc[AccWidth-1:0]} + AccStep;
         syncFf <= {syncFf[0], rx.RxD};
         if (tick) hist <= {hist[1:0], syncFf[1]};
      end
   end

   always_comb begin
      stateNext  = state;
      phaseNext  = phase;
      bitCntNext = bitCnt;
      shiftNext  = shiftReg;
      loadData   = 1'b0;
      frameErr   = 1'b0;
      if (tick) begin
         case (state)
            sIdle: if (!rxBit) begin
               stateNext = sStart;
               phaseNext = '0;
            end
            sStart: begin
               phaseNext = phase + 1'b1;
               if (phase == PhaseMid) begin
                  if (!rxBit) begin
                     stateNext  = sData;
                     phaseNext  = '0;
                     bitCntNext = '0;
                  end else begin
                     stateNext = sIdle;
                  end
               end
            end
            // phase wraps to 0 at PhaseEnd, so each bit is a full Oversampling ticks
            sData: begin
               phaseNext = phase + 1'b1;
               if (phase == PhaseEnd) begin
                  shiftNext  = {rxBit, shiftReg[7:1]};
                  bitCntNext = bitCnt + 3'd1;
                  if (bitCnt == 3'd7) stateNext = sStop;
               end
            end
            sStop: begin
               phaseNext = phase + 1'b1;
               if (phase == PhaseEnd) begin
                  if (rxBit) begin
                     loadData  = 1'b1;
                     stateNext = sIdle;
                  end else begin
                     frameErr  = 1'b1;
                     stateNext = sBreak;
                  end
               end
            end
            sBreak: if (rxBit) stateNext = sIdle;
            default: stateNext = sIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= sIdle;
         phase              <= '0;
         bitCnt             <= '0;
         shiftReg           <= '0;
         idleCnt            <= '0;
         rx.RxD_data        <= '0;
         rx.RxD_data_ready  <= 1'b0;
         rx.RxD_framing_err <= 1'b0;
      end else begin
         state              <= stateNext;
         phase              <= phaseNext;
         bitCnt             <= bitCntNext;
         shiftReg           <= shiftNext;
         rx.RxD_data_ready  <= loadData;
         rx.RxD_framing_err <= frameErr;
         if (loadData) rx.RxD_data <= shiftReg;
         if (state != sIdle)
            idleCnt <= '0;
         else if (tick && rxBit && idleCnt != IdleW'(IdleMax))
            idleCnt <= idleCnt + 1'b1;
      end
   end

   assign rx.RxD_busy = (state != sIdle);
   assign rx.RxD_idle = (idleCnt == IdleW'(IdleMax));
endmodule
